// File: rtl/subbytes_serial_engine.sv
// Drives one shared S-box with a full 128-bit AES state, one byte per cycle,
// for SubBytes (encrypt=1) or InvSubBytes (encrypt=0).
module subbytes_serial_engine #(
  parameter int SBOX_LAT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_encrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [7:0]   sbox_byte_in,
  output logic         sbox_encrypt,
  input  logic [7:0]   sbox_byte_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  // Byte k lives at index 15-k (== ~k for a 4-bit k), matching in_state ordering.
  logic [15:0][7:0] work_q, res_q;
  logic [3:0]       issue_idx, res_idx, nxt_idx;
  logic             dir_q, iss_done, iss_vld_q;
  logic             iss_vld, cap_vld;

  assign nxt_idx      = issue_idx + 4'd1;
  assign iss_vld      = (state == RUN) && !iss_done;
  // A result is valid SBOX_LAT cycles after its byte was issued.
  assign cap_vld      = (SBOX_LAT == 0) ? iss_vld : ((state == RUN) && iss_vld_q);
  assign sbox_encrypt = dir_q;
  assign out_state    = res_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      work_q       <= '0;
      res_q        <= '0;
      issue_idx    <= '0;
      res_idx      <= '0;
      dir_q        <= 1'b1;
      iss_done     <= 1'b0;
      iss_vld_q    <= 1'b0;
      sbox_byte_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work_q       <= in_state;
            dir_q        <= in_encrypt;
            sbox_byte_in <= in_state[127:120];
            issue_idx    <= '0;
            res_idx      <= '0;
            iss_done     <= 1'b0;
            iss_vld_q    <= 1'b0;
            in_ready     <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          iss_vld_q <= iss_vld;
          if (iss_vld) begin
            if (issue_idx == 4'd15) begin
              iss_done <= 1'b1;
            end else begin
              issue_idx    <= nxt_idx;
              sbox_byte_in <= work_q[~nxt_idx];
            end
          end
          if (cap_vld) begin
            res_q[~res_idx] <= sbox_byte_out;
            if (res_idx == 4'd15) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              res_idx <= res_idx + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_serial_engine.sv
// Bench: instance 0 uses a combinational S-box (SBOX_LAT=0), instance 1 a registered
// one (SBOX_LAT=1); both checked every cycle against a GF(2^8)-based reference.
module tb_subbytes_serial_engine;

  logic         clk, reset_n;
  logic         in_valid[2], in_ready[2], in_enc[2], out_valid[2], out_ready[2];
  logic [127:0] in_state[2], out_state[2];
  logic [7:0]   sbox_in[2], sbox_out[2];
  logic         sbox_enc[2];

  int checks = 0, errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  localparam logic [127:0] VEC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SUB = 128'h638293c31bfc33f5c4eeacea4bc12816;

  subbytes_serial_engine #(.SBOX_LAT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_encrypt(in_enc[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .sbox_byte_in(sbox_in[0]),
    .sbox_encrypt(sbox_enc[0]), .sbox_byte_out(sbox_out[0]));

  subbytes_serial_engine #(.SBOX_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_encrypt(in_enc[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .sbox_byte_in(sbox_in[1]),
    .sbox_encrypt(sbox_enc[1]), .sbox_byte_out(sbox_out[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES S-box from field arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x, input logic enc);
    logic [7:0] b;
    if (enc) begin
      b = ginv(x);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s, input logic enc);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sb(byte_of(s, k), enc);
    return r;
  endfunction

  // External S-box instances seen by the two DUTs.
  always_comb sbox_out[0] = sb(sbox_in[0], sbox_enc[0]);
  always @(posedge clk) sbox_out[1] <= sb(sbox_in[1], sbox_enc[1]);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- Reference timeline (instance d has SBOX_LAT=d) ----------------
  logic         m_ready[2], m_ov[2], m_busy[2], m_dir[2];
  logic [7:0]   m_bin[2];
  logic [127:0] m_st[2], m_exp[2], m_out[2];
  int           m_cnt[2], last_x[2], prev_x[2];

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_ready[d] <= 1'b1; m_ov[d] <= 1'b0; m_busy[d] <= 1'b0; m_dir[d] <= 1'b1;
        m_bin[d] <= 8'h00; m_out[d] <= '0; m_cnt[d] <= 0;
      end else if (m_ready[d]) begin
        if (in_valid[d]) begin
          m_ready[d] <= 1'b0; m_busy[d] <= 1'b1; m_cnt[d] <= 0;
          m_st[d] <= in_state[d]; m_dir[d] <= in_enc[d];
          m_bin[d] <= byte_of(in_state[d], 0);
          m_exp[d] <= sub_state(in_state[d], in_enc[d]);
          prev_x[d] <= last_x[d]; last_x[d] <= cyc;
        end
      end else if (m_busy[d]) begin
        m_cnt[d] <= m_cnt[d] + 1;
        m_bin[d] <= byte_of(m_st[d], (m_cnt[d] + 1 > 15) ? 15 : m_cnt[d] + 1);
        if (m_cnt[d] + 1 == 16 + d) begin
          m_busy[d] <= 1'b0; m_ov[d] <= 1'b1; m_out[d] <= m_exp[d];
        end
      end else if (m_ov[d] && out_ready[d]) begin
        m_ov[d] <= 1'b0; m_ready[d] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready[%0d]", d), 128'(in_ready[d]), 128'(m_ready[d]));
        chk($sformatf("out_valid[%0d]", d), 128'(out_valid[d]), 128'(m_ov[d]));
        chk($sformatf("sbox_encrypt[%0d]", d), 128'(sbox_enc[d]), 128'(m_dir[d]));
        chk($sformatf("sbox_byte_in[%0d]", d), 128'(sbox_in[d]), 128'(m_bin[d]));
        if (m_ready[d] || m_ov[d])
          chk($sformatf("out_state[%0d]", d), out_state[d], m_out[d]);
      end
    end
  end

  // ---------------- Stimulus helpers (called at a negedge) ----------------
  task automatic send(input int d, input logic [127:0] s, input logic e);
    int n = 0;
    in_valid[d] = 1'b1; in_state[d] = s; in_enc[d] = e;
    while (!in_ready[d] && n < 60) begin @(negedge clk); n++; end
    chk($sformatf("send_ready[%0d]", d), 128'(in_ready[d]), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input bit scr, output logic [127:0] res,
                           output int lat, output logic enc_any);
    lat = 1; enc_any = 1'b0;
    while (!out_valid[d] && lat < 60) begin
      enc_any = enc_any | sbox_enc[d];
      if (scr) begin
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        in_enc[d] = 1'($urandom); in_valid[d] = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    chk($sformatf("done_seen[%0d]", d), 128'(out_valid[d]), 128'(1));
    in_valid[d] = 1'b0;
    res = out_state[d];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] res, x, y;
    logic         e, enc_any;
    int           lat;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0; in_enc[d] = 0; out_ready[d] = 0; in_state[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 128'(in_ready[d]), 128'(1));
      chk("rst_out_valid", 128'(out_valid[d]), 128'(0));
      chk("rst_out_state", out_state[d], 128'(0));
      chk("rst_sbox_byte_in", 128'(sbox_in[d]), 128'(0));
      chk("rst_sbox_encrypt", 128'(sbox_enc[d]), 128'(1));
    end
    // Pin the reference against known AES values.
    chk("model_fwd", sub_state(VEC, 1'b1), SUB);
    chk("model_inv", sub_state(SUB, 1'b0), VEC);
    chk("model_53", 128'(sb(8'h53, 1'b1)), 128'(8'hed));
    reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Forward, combinational S-box.
    out_ready[0] = 1'b1;
    send(0, VEC, 1'b1);
    wait_done(0, 1'b0, res, lat, enc_any);
    chk("fwd_result", res, SUB);
    chk("fwd_latency", 128'(lat), 128'(17));
    @(negedge clk);
    chk("fwd_valid_one_cycle", 128'(out_valid[0]), 128'(0));

    // Inverse round trip, registered S-box.
    out_ready[1] = 1'b1;
    send(1, SUB, 1'b0);
    wait_done(1, 1'b0, res, lat, enc_any);
    chk("inv_result", res, VEC);
    chk("inv_latency", 128'(lat), 128'(18));
    chk("inv_sbox_encrypt_low", 128'(enc_any), 128'(0));
    @(negedge clk);

    // Backpressure with junk on the input side.
    for (int d = 0; d < 2; d++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      out_ready[d] = 1'b0;
      send(d, x, 1'b1);
      wait_done(d, 1'b1, res, lat, enc_any);
      chk("bp_result", res, sub_state(x, 1'b1));
      for (int i = 0; i < 10; i++) begin
        in_valid[d] = 1'($urandom);
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("bp_in_ready_low", 128'(in_ready[d]), 128'(0));
        chk("bp_out_state_held", out_state[d], res);
      end
      y = {$urandom, $urandom, $urandom, $urandom};
      e = 1'($urandom);
      in_valid[d] = 1'b1; in_state[d] = y; in_enc[d] = e; out_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_not_yet_accepted", 128'(in_ready[d]), 128'(1));
      @(posedge clk);
      @(negedge clk);
      chk("bp_accepted", 128'(in_ready[d]), 128'(0));
      in_valid[d] = 1'b0;
      wait_done(d, 1'b0, res, lat, enc_any);
      chk("bp_second_result", res, sub_state(y, e));
      @(negedge clk);
    end

    // Inputs changing during RUN must not matter.
    for (int d = 0; d < 2; d++) begin
      send(d, '0, 1'b1);
      wait_done(d, 1'b1, res, lat, enc_any);
      chk("stable_result", res, {16{8'h63}});
      @(negedge clk);
    end

    // Reset in the middle of RUN.
    fork
      send(0, VEC, 1'b1);
      send(1, VEC, 1'b1);
    join
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_in_ready", 128'(in_ready[d]), 128'(1));
      chk("arst_out_valid", 128'(out_valid[d]), 128'(0));
      chk("arst_out_state", out_state[d], 128'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      send(d, {16{8'h53}}, 1'b1);
      wait_done(d, 1'b0, res, lat, enc_any);
      chk("post_rst_result", res, {16{8'hed}});
      chk("post_rst_latency", 128'(lat), 128'(17 + d));
      @(negedge clk);
    end

    // Back-to-back with in_valid held.
    for (int d = 0; d < 2; d++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom, $urandom};
      out_ready[d] = 1'b1;
      send(d, x, 1'b1);
      in_valid[d] = 1'b1; in_state[d] = y; in_enc[d] = 1'b0;
      lat = 0;
      while (!out_valid[d] && lat < 60) begin @(negedge clk); lat++; end
      chk("b2b_first", out_state[d], sub_state(x, 1'b1));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0;
      chk("b2b_period", 128'(last_x[d] - prev_x[d]), 128'(18 + d));
      wait_done(d, 1'b0, res, lat, enc_any);
      chk("b2b_second", res, sub_state(y, 1'b0));
      @(negedge clk);
    end

    // Random traffic with random stalls; the per-cycle compare does the checking.
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        e = 1'($urandom);
        out_ready[d] = 1'b0;
        send(d, x, e);
        wait_done(d, 1'b1, res, lat, enc_any);
        chk("rand_result", res, sub_state(x, e));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        out_ready[d] = 1'b1;
        @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/subbytes_serial_engine.md
Name: subbytes_serial_engine

Overview:
- Initiator/driver for the shared bitsliced S-box: sequences a full 128-bit AES state through one external S-box instance, one byte per cycle.
- Performs SubBytes (encrypt=1) or InvSubBytes (encrypt=0) on the whole state.
- Sits between the round-control datapath (valid/ready handshake on both sides) and the S-box byte port (byte_in/encrypt/byte_out).

Parameters:
- SBOX_LAT, 0, S-box result latency in cycles. 0 means combinational: the result is sampled in the same cycle the byte is driven. 1 means the S-box output is registered: the result is sampled one cycle after drive. Other values are illegal.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input state is valid
- in_ready  output  1  engine can accept a state
- in_state  input  128  state to substitute; byte k = in_state[127-8k -: 8], k=0..15
- in_encrypt  input  1  1 = forward S-box, 0 = inverse S-box
- out_valid  output  1  out_state holds a finished result
- out_ready  input  1  consumer accepts the result
- out_state  output  128  substituted state, same byte ordering as in_state
- sbox_byte_in  output  8  byte driven to the S-box
- sbox_encrypt  output  1  direction driven to the S-box
- sbox_byte_out  input  8  S-box result

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE; in_ready=1; out_valid=0; out_state=0.
  - sbox_byte_in=0; sbox_encrypt=1; internal byte counters=0.
- States:
  - IDLE: in_ready=1. Transfer when in_valid&&in_ready. On transfer, latch in_state into the working buffer, latch in_encrypt into dir_q, clear counters, and go to RUN.
  - RUN: in_ready=0.
    - Drive counter issue_idx 0..15; sbox_byte_in = working byte[issue_idx]; sbox_encrypt = dir_q.
    - Result counter res_idx trails issue_idx by SBOX_LAT. Each cycle with a valid result, write sbox_byte_out into result byte[res_idx].
    - With SBOX_LAT=0: 16 cycles in RUN.
    - With SBOX_LAT=1: 17 cycles in RUN. Cycle 0 issues only. The final cycle captures only, and sbox_byte_in holds byte 15.
    - After byte 15 is captured, go to DONE.
  - DONE: out_valid=1; out_state = result buffer, held stable. When out_valid&&out_ready, go to IDLE and clear out_valid in the same edge.
- Outside RUN: sbox_byte_in holds its last value; sbox_encrypt = dir_q.
- Latency, from the in_valid&&in_ready edge to out_valid high: 17 cycles (SBOX_LAT=0) or 18 cycles (SBOX_LAT=1).
- Throughput: one state per 18 cycles (SBOX_LAT=0) or 19 cycles (SBOX_LAT=1) with out_ready tied high.
- in_ready is 0 in RUN and DONE. No input is accepted until the result is consumed; there is no overlap.
- in_encrypt and in_state are ignored except on the transfer edge. Changing them mid-operation has no effect.
- out_ready is ignored unless in DONE. out_state changes only on a RUN capture.
- out_valid with out_ready held low: out_valid and out_state are held indefinitely.
- Counters are 4 bits. Termination is on index==15, never on wrap-around.
- reset_n low in any state aborts the operation immediately. The partial result is discarded, all outputs return to reset values, and no out_valid follows.
- One S-box instance; exactly one byte is issued per RUN cycle; no bubbles.

Test Plan:
- Forward, SBOX_LAT=0:
  - Stimulus: in_state=0x00112233445566778899aabbccddeeff, in_encrypt=1, out_ready=1.
  - Required: out_state=0x638293c31bfc33f5c4eeacea4bc12816, out_valid high exactly 17 cycles after transfer, for one cycle.
  - Required: sbox_byte_in sequence is 00,11,...,ff in order.
- Inverse round-trip, SBOX_LAT=1:
  - Stimulus: feed 0x638293c31bfc33f5c4eeacea4bc12816 with in_encrypt=0.
  - Required: out_state=0x00112233445566778899aabbccddeeff, out_valid at cycle 18, sbox_encrypt=0 throughout RUN.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises; toggle in_valid with random data.
  - Required: out_state stable, in_ready=0, second state not accepted until the cycle after out_ready=1.
- Input stability:
  - Stimulus: all-0x00 state with encrypt=1; flip in_encrypt and in_state every RUN cycle.
  - Required: out_state=0x63 repeated 16 times.
- Reset mid-operation:
  - Stimulus: deassert reset_n at RUN byte 7.
  - Required: in_ready=1 and out_valid=0 asynchronously. After release, a new state 0x53 repeated 16 times gives 0xed repeated 16 times with normal latency.
- Back-to-back:
  - Stimulus: two states with out_ready=1 and in_valid held.
  - Required: second transfer occurs on the edge after out_valid handshake; results correct; period 18 cycles (SBOX_LAT=0).
